// File: rtl/mux4x1_rr_sched.sv
// -----------------------------------------------------------------------------
// mux4x1_rr_sched
//
// Shares one DATA_W-bit output byte path between four lane requesters.
// Each lane has a one-entry holding register filled over a valid/ready
// handshake. A rotating-priority arbiter moves one held byte per cycle into
// a registered output stage that honours downstream backpressure.
//
// Ports:
//   clk        single clock for all state
//   reset      asynchronous, active-low reset
//   in0..in3   lane data, qualified by valid[i]
//   valid[3:0] per-lane valid
//   ready[3:0] per-lane ready (combinational, depends on out_ready)
//   out_ready  downstream accepts the output byte this cycle
//   out        scheduled byte (registered)
//   validout   out holds a valid byte (registered)
//   sel        lane index of the byte on out (registered)
// -----------------------------------------------------------------------------
module mux4x1_rr_sched #(
  parameter int DATA_W  = 8,
  parameter int PTR_RST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [3:0]        valid,
  output logic [3:0]        ready,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic              validout,
  output logic [1:0]        sel
);

  localparam logic [1:0] PTR_INIT = 2'(PTR_RST);

  logic [DATA_W-1:0] w_in [4];
  logic [DATA_W-1:0] r_hold [4];
  logic [3:0]        r_full;
  logic [1:0]        r_ptr;
  logic [DATA_W-1:0] r_out;
  logic              r_validout;
  logic [1:0]        r_sel;

  logic              w_free;
  logic              w_gnt_any;
  logic [1:0]        w_gnt_idx;
  logic [3:0]        w_grant;
  logic [3:0]        w_accept;

  assign w_in[0] = in0;
  assign w_in[1] = in1;
  assign w_in[2] = in2;
  assign w_in[3] = in3;

  // The output register can take a new byte when it is empty or is being
  // consumed this cycle.
  assign w_free = ~r_validout | out_ready;

  // Search lanes starting at the priority pointer; first full lane wins.
  always_comb begin
    logic [1:0] probe;
    w_gnt_any = 1'b0;
    w_gnt_idx = r_ptr;
    probe     = r_ptr;
    for (int k = 0; k < 4; k++) begin
      probe = r_ptr + 2'(k);
      if (w_free && !w_gnt_any && r_full[probe]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = probe;
      end
    end
  end

  assign w_grant = w_gnt_any ? (4'b0001 << w_gnt_idx) : 4'b0000;

  // A lane being drained this cycle can refill at the same edge, which lets
  // a single busy lane sustain one byte per clock.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign ready[gi]    = ~r_full[gi] | w_grant[gi];
      assign w_accept[gi] = valid[gi] & ready[gi];
    end
  endgenerate

  // Holding registers: accept wins over drain so grant+accept stays full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_accept[i]) begin
          r_hold[i] <= w_in[i];
          r_full[i] <= 1'b1;
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // Output stage and priority pointer. When stalled everything holds; when
  // free without a grant only validout drops, out/sel keep their last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out      <= '0;
      r_validout <= 1'b0;
      r_sel      <= 2'd0;
      r_ptr      <= PTR_INIT;
    end else if (w_free) begin
      if (w_gnt_any) begin
        r_out      <= r_hold[w_gnt_idx];
        r_validout <= 1'b1;
        r_sel      <= w_gnt_idx;
        r_ptr      <= w_gnt_idx + 2'd1;
      end else begin
        r_validout <= 1'b0;
      end
    end
  end

  assign out      = r_out;
  assign validout = r_validout;
  assign sel      = r_sel;

endmodule

// File: tb/tb_mux4x1_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mux4x1_rr_sched
//
// Directed bench for mux4x1_rr_sched. Inputs change 1 time unit after each
// rising edge; registered outputs are sampled there, combinational ready is
// sampled one more unit later once the new inputs have settled.
// -----------------------------------------------------------------------------
module tb_mux4x1_rr_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] valid;
  logic [3:0] ready;
  logic       out_ready;
  logic [7:0] out;
  logic       validout;
  logic [1:0] sel;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux4x1_rr_sched #(
    .DATA_W (8),
    .PTR_RST(0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .valid    (valid),
    .ready    (ready),
    .out_ready(out_ready),
    .out      (out),
    .validout (validout),
    .sel      (sel)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One line per observed output transaction, then the checks.
  task automatic expect_out(input string tag, input logic v,
                            input logic [7:0] d, input logic [1:0] s);
    $display("[%0t] %s: validout=%0b out=%02h sel=%0d ready=%04b",
             $time, tag, validout, out, sel, ready);
    check_val({tag, ".validout"}, {31'd0, validout}, {31'd0, v});
    if (v) begin
      check_val({tag, ".out"}, {24'd0, out}, {24'd0, d});
      check_val({tag, ".sel"}, {30'd0, sel}, {30'd0, s});
    end
  endtask

  task automatic expect_ready(input string tag, input logic [3:0] r);
    #1;
    check_val({tag, ".ready"}, {28'd0, ready}, {28'd0, r});
  endtask

  initial begin
    reset     = 1'b0;
    valid     = 4'b0000;
    in0       = 8'h00;
    in1       = 8'h00;
    in2       = 8'h00;
    in3       = 8'h00;
    out_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    expect_out("rst", 1'b0, 8'h00, 2'd0);
    check_val("rst.out", {24'd0, out}, 32'h0);
    check_val("rst.sel", {30'd0, sel}, 32'h0);
    expect_ready("rst", 4'b1111);
    reset = 1'b1;

    // Single lane streaming
    valid = 4'b0001; in0 = 8'h01;
    expect_ready("s0", 4'b1111);
    tick();
    expect_out("s1", 1'b0, 8'h00, 2'd0);
    in0 = 8'h02;
    expect_ready("s1", 4'b1111);
    tick();
    expect_out("s2", 1'b1, 8'h01, 2'd0);
    in0 = 8'h03;
    expect_ready("s2", 4'b1111);
    tick();
    expect_out("s3", 1'b1, 8'h02, 2'd0);
    valid = 4'b0000;
    tick();
    expect_out("s4", 1'b1, 8'h03, 2'd0);
    tick();
    expect_out("s5", 1'b0, 8'h00, 2'd0);

    // Reset between tests, pointer back to lane 0
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // All lanes round-robin
    valid = 4'b1111;
    in0 = 8'hA0; in1 = 8'hB1; in2 = 8'hC2; in3 = 8'hD3;
    tick();
    valid = 4'b0000;
    expect_out("rr0", 1'b0, 8'h00, 2'd0);
    expect_ready("rr0", 4'b0001);
    tick(); expect_out("rr1", 1'b1, 8'hA0, 2'd0);
    tick(); expect_out("rr2", 1'b1, 8'hB1, 2'd1);
    tick(); expect_out("rr3", 1'b1, 8'hC2, 2'd2);
    tick(); expect_out("rr4", 1'b1, 8'hD3, 2'd3);
    tick(); expect_out("rr5", 1'b0, 8'h00, 2'd0);

    // Pointer wrapped to 0: lanes 2 and 0 together, lane 0 first
    valid = 4'b0101; in0 = 8'h10; in2 = 8'h12;
    tick();
    valid = 4'b0000;
    tick(); expect_out("wr1", 1'b1, 8'h10, 2'd0);
    tick(); expect_out("wr2", 1'b1, 8'h12, 2'd2);
    tick(); expect_out("wr3", 1'b0, 8'h00, 2'd0);

    // Backpressure: pointer now 3, load all lanes, refill lane 3 on its grant
    valid = 4'b1111;
    in0 = 8'h20; in1 = 8'h21; in2 = 8'h22; in3 = 8'h23;
    tick();
    valid = 4'b1000; in3 = 8'h33;
    expect_ready("bp0", 4'b1000);
    tick();
    expect_out("bp1", 1'b1, 8'h23, 2'd3);
    valid = 4'b0000; out_ready = 1'b0;
    expect_ready("bp1", 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("bp_stall", 1'b1, 8'h23, 2'd3);
      expect_ready("bp_stall", 4'b0000);
    end
    out_ready = 1'b1;
    expect_ready("bp_rel", 4'b0001);
    tick(); expect_out("bp2", 1'b1, 8'h20, 2'd0);
    tick(); expect_out("bp3", 1'b1, 8'h21, 2'd1);
    tick(); expect_out("bp4", 1'b1, 8'h22, 2'd2);
    tick(); expect_out("bp5", 1'b1, 8'h33, 2'd3);
    tick(); expect_out("bp6", 1'b0, 8'h00, 2'd0);

    // Lane 1 refilled on its own grant; waits behind lanes 2, 3, 0
    valid = 4'b1111;
    in0 = 8'h40; in1 = 8'h41; in2 = 8'h42; in3 = 8'h43;
    tick();
    valid = 4'b0000;
    tick(); expect_out("sp1", 1'b1, 8'h40, 2'd0);
    valid = 4'b0011; in0 = 8'h50; in1 = 8'h51;
    expect_ready("sp1", 4'b0011);
    tick(); expect_out("sp2", 1'b1, 8'h41, 2'd1);
    valid = 4'b0000;
    tick(); expect_out("sp3", 1'b1, 8'h42, 2'd2);
    tick(); expect_out("sp4", 1'b1, 8'h43, 2'd3);
    tick(); expect_out("sp5", 1'b1, 8'h50, 2'd0);
    tick(); expect_out("sp6", 1'b1, 8'h51, 2'd1);
    tick(); expect_out("sp7", 1'b0, 8'h00, 2'd0);

    // Mid-traffic reset with all lanes full and validout=1 (pointer is 2)
    valid = 4'b1111;
    in0 = 8'h60; in1 = 8'h61; in2 = 8'h62; in3 = 8'h63;
    tick();
    tick(); expect_out("mr0", 1'b1, 8'h62, 2'd2);
    reset = 1'b0;
    #1;
    expect_out("mr1", 1'b0, 8'h00, 2'd0);
    check_val("mr1.out", {24'd0, out}, 32'h0);
    check_val("mr1.sel", {30'd0, sel}, 32'h0);
    check_val("mr1.ready", {28'd0, ready}, 32'hF);
    valid = 4'b0000;
    tick();
    reset = 1'b1;
    tick(); expect_out("mr2", 1'b0, 8'h00, 2'd0);
    tick(); expect_out("mr3", 1'b0, 8'h00, 2'd0);

    // Pointer restored to lane 0: lanes 3 and 1 -> lane 1 first, no stale data
    valid = 4'b1010; in1 = 8'h71; in3 = 8'h73;
    tick();
    valid = 4'b0000;
    tick(); expect_out("pr1", 1'b1, 8'h71, 2'd1);
    tick(); expect_out("pr2", 1'b1, 8'h73, 2'd3);
    tick(); expect_out("pr3", 1'b0, 8'h00, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
